// File: rtl/eth_send_scheduler.sv
// Packet launch scheduler between the encoder->Ethernet FIFO read side and the UDP/MAC TX engine.
// Decides payload size and launch time, stamps sequence numbers, enforces inter-packet gap.
module eth_send_scheduler #(
  parameter int LEVEL_W       = 15,
  parameter int PAYLOAD_BYTES = 1024,
  parameter int TIMEOUT_CYC   = 125000,
  parameter int GAP_CYC       = 96,
  parameter int SEQ_W         = 16
) (
  input  logic               eth_clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [LEVEL_W-1:0] fifo_level,
  input  logic               flush_req,
  input  logic               byte_taken,
  input  logic               tx_done,
  output logic               start_send,
  output logic [15:0]        payload_len,
  output logic [SEQ_W-1:0]   seq_no,
  output logic               busy,
  output logic               err_len,
  output logic [31:0]        pkt_count
);

  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam int GAP_W = $clog2(GAP_CYC + 1);
  localparam logic [LEVEL_W-1:0] FULL_LVL = LEVEL_W'(PAYLOAD_BYTES);
  localparam logic [TMR_W-1:0]   TMR_MAX  = TMR_W'(TIMEOUT_CYC);
  localparam logic [GAP_W-1:0]   GAP_END  = GAP_W'(GAP_CYC - 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, SEND, GAP} state_t;

  state_t           state;
  logic [TMR_W-1:0] idle_timer;
  logic [GAP_W-1:0] gap_cnt;
  logic [15:0]      take_cnt;
  logic             flush_pending;

  logic        level_nz, level_full, launch;
  logic [15:0] take_total;

  assign level_nz   = |fifo_level;
  assign level_full = fifo_level >= FULL_LVL;
  assign launch     = (state == IDLE) && enable &&
                      (level_full || (level_nz && (flush_pending || idle_timer == TMR_MAX)));
  // a byte_taken coincident with tx_done belongs to the packet
  assign take_total = take_cnt + 16'(byte_taken);

  always_ff @(posedge eth_clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      idle_timer    <= '0;
      gap_cnt       <= '0;
      take_cnt      <= '0;
      flush_pending <= 1'b0;
      start_send    <= 1'b0;
      payload_len   <= '0;
      seq_no        <= '0;
      busy          <= 1'b0;
      err_len       <= 1'b0;
      pkt_count     <= '0;
    end else begin
      if (flush_req)
        flush_pending <= 1'b1;
      else if (launch && fifo_level <= FULL_LVL)
        flush_pending <= 1'b0;

      case (state)
        IDLE: begin
          if (tx_done || byte_taken) err_len <= 1'b1;
          if (launch) begin
            payload_len <= level_full ? 16'(PAYLOAD_BYTES) : 16'(fifo_level);
            idle_timer  <= '0;
            start_send  <= 1'b1;
            busy        <= 1'b1;
            state       <= LAUNCH;
          end else if (!level_nz) begin
            idle_timer <= '0;
          end else if (idle_timer != TMR_MAX) begin
            idle_timer <= idle_timer + TMR_W'(1);
          end
        end
        LAUNCH: begin
          start_send <= 1'b0;
          take_cnt   <= take_total;
          if (tx_done) err_len <= 1'b1;
          state      <= SEND;
        end
        SEND: begin
          if (tx_done) begin
            if (take_total != payload_len) err_len <= 1'b1;
            seq_no    <= seq_no + SEQ_W'(1);
            pkt_count <= pkt_count + 32'd1;
            take_cnt  <= '0;
            // the tx_done cycle is the first cycle of the gap
            gap_cnt   <= GAP_W'(1);
            state     <= GAP;
          end else begin
            take_cnt <= take_total;
          end
        end
        GAP: begin
          if (tx_done || byte_taken) err_len <= 1'b1;
          if (gap_cnt >= GAP_END) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_send_scheduler.sv
// Bench for eth_send_scheduler: directed scenarios plus randomized packets, all outputs
// compared every cycle against a transaction-level model; literal checks pin the model.
module tb_eth_send_scheduler;
  localparam int LEVEL_W = 15;
  localparam int PB      = 1024;
  localparam int TO      = 300;
  localparam int GAP     = 96;
  localparam int SEQ_W   = 4;

  logic               eth_clk = 1'b0;
  logic               rst_n = 1'b1;
  logic               enable = 1'b0;
  logic [LEVEL_W-1:0] fifo_level = '0;
  logic               flush_req = 1'b0;
  logic               byte_taken = 1'b0;
  logic               tx_done = 1'b0;
  logic               start_send;
  logic [15:0]        payload_len;
  logic [SEQ_W-1:0]   seq_no;
  logic               busy;
  logic               err_len;
  logic [31:0]        pkt_count;

  eth_send_scheduler #(.LEVEL_W(LEVEL_W), .PAYLOAD_BYTES(PB), .TIMEOUT_CYC(TO),
                       .GAP_CYC(GAP), .SEQ_W(SEQ_W)) dut (
    .eth_clk(eth_clk), .rst_n(rst_n), .enable(enable), .fifo_level(fifo_level),
    .flush_req(flush_req), .byte_taken(byte_taken), .tx_done(tx_done),
    .start_send(start_send), .payload_len(payload_len), .seq_no(seq_no), .busy(busy),
    .err_len(err_len), .pkt_count(pkt_count));

  always #5 eth_clk = ~eth_clk;

  int n_chk = 0, n_fail = 0, n_done = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 waiting for data, 1 launch pulse, 2 packet on the wire, 3 inter-packet gap
  int m_phase = 0, m_timer = 0, m_gap_left = 0, m_taken = 0, m_len = 0, m_seq = 0, m_pkts = 0;
  bit m_fp = 0, m_start = 0, m_busy = 0, m_err = 0;

  always @(posedge eth_clk or negedge rst_n) begin : model
    int  lvl;
    bit  fp_was, go;
    if (!rst_n) begin
      m_phase = 0; m_timer = 0; m_gap_left = 0; m_taken = 0; m_len = 0;
      m_seq = 0; m_pkts = 0; m_fp = 0; m_start = 0; m_busy = 0; m_err = 0;
    end else begin
      lvl    = int'(fifo_level);
      fp_was = m_fp;
      if (flush_req) m_fp = 1;
      case (m_phase)
        0: begin
          if (tx_done || byte_taken) m_err = 1;
          go = enable && (lvl >= PB || (lvl != 0 && (fp_was || m_timer == TO)));
          if (go) begin
            m_len = (lvl < PB) ? lvl : PB;
            if (lvl <= PB && !flush_req) m_fp = 0;
            m_timer = 0; m_start = 1; m_busy = 1; m_phase = 1;
          end else if (lvl == 0) m_timer = 0;
          else if (m_timer < TO) m_timer++;
        end
        1: begin
          m_start = 0;
          if (byte_taken) m_taken++;
          if (tx_done) m_err = 1;
          m_phase = 2;
        end
        2: begin
          if (byte_taken) m_taken++;
          if (tx_done) begin
            if (m_taken != m_len) m_err = 1;
            m_seq = (m_seq + 1) % (1 << SEQ_W);
            m_pkts++;
            m_taken = 0;
            m_gap_left = GAP - 1;
            m_phase = 3;
          end
        end
        default: begin
          if (tx_done || byte_taken) m_err = 1;
          m_gap_left--;
          if (m_gap_left <= 0) begin m_busy = 0; m_phase = 0; end
        end
      endcase
    end
  end

  always @(negedge eth_clk)
    check("cycle outputs {start,len,seq,busy,err,pkts}",
          64'({start_send, payload_len, seq_no, busy, err_len, pkt_count}),
          64'({m_start, 16'(m_len), SEQ_W'(m_seq), m_busy, m_err, 32'(m_pkts)}));

  // ---------------- stimulus helpers ----------------
  task automatic tick(int n = 1);
    repeat (n) begin @(posedge eth_clk); #1; end
  endtask

  task automatic wait_start(int limit, output int waited);
    waited = 0;
    while (start_send !== 1'b1 && waited < limit) begin tick(); waited++; end
    check("start_send within bound", 64'(start_send === 1'b1), 64'd1);
  endtask

  task automatic flush_pulse();
    flush_req = 1'b1; tick(); flush_req = 1'b0;
  endtask

  task automatic take_one();
    byte_taken = 1'b1;
    if (fifo_level != 0) fifo_level = fifo_level - 1'b1;
  endtask

  // consume nb bytes then pulse tx_done; overlap puts the last byte on the tx_done cycle
  task automatic serve(int nb, bit overlap, bit drop_en);
    int last;
    last = (overlap && nb > 0) ? nb - 1 : nb;
    for (int i = 0; i < last; i++) begin
      if (drop_en && i == nb / 2) enable = 1'b0;
      take_one(); tick(); byte_taken = 1'b0;
      if ($urandom_range(3) == 0) tick();
    end
    if (overlap && nb > 0) take_one();
    tx_done = 1'b1; tick(); tx_done = 1'b0; byte_taken = 1'b0;
    n_done++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, p0, nb;
    int lens[3];

    #2 rst_n = 1'b0;
    tick(3);
    check("reset outputs", 64'({start_send, payload_len, seq_no, busy, err_len, pkt_count}), 64'd0);
    rst_n = 1'b1; enable = 1'b1;
    tick(2);

    // full packet: pulse one cycle after level reaches PB
    fifo_level = 15'(PB);
    wait_start(5, w);
    check("full launch latency", 64'(w), 64'd1);
    check("full payload_len", 64'(payload_len), 64'd1024);
    check("first seq_no", 64'(seq_no), 64'd0);
    serve(PB, 0, 0);
    check("after pkt1 err_len", 64'(err_len), 64'd0);
    check("after pkt1 seq_no", 64'(seq_no), 64'd1);
    check("after pkt1 pkt_count", 64'(pkt_count), 64'd1);
    tick(GAP);

    // partial data with no flush waits for the idle timeout
    fifo_level = 15'd300;
    wait_start(TO + 20, w);
    check("timeout launch latency", 64'(w), 64'(TO + 1));
    check("timeout payload_len", 64'(payload_len), 64'd300);
    serve(300, 1, 0);
    check("overlap byte err_len", 64'(err_len), 64'd0);

    // flush with 2500 bytes: 1024, 1024, 452 and gap-limited spacing
    fifo_level = 15'd2500;
    flush_pulse();
    for (int k = 0; k < 3; k++) begin
      wait_start(GAP + 20, w);
      if (k > 0) check("tx_done to start_send gap", 64'(w), 64'(GAP));
      lens[k] = int'(payload_len);
      serve(lens[k], 0, 0);
    end
    check("flush pkt0 len", 64'(lens[0]), 64'd1024);
    check("flush pkt1 len", 64'(lens[1]), 64'd1024);
    check("flush pkt2 len", 64'(lens[2]), 64'd452);
    tick(GAP);
    fifo_level = 15'd5;
    tick(50);
    check("flush cleared, no early launch", 64'(busy), 64'd0);
    fifo_level = '0;
    tick(2);

    // enable low holds off; re-enable launches; dropping enable mid-send completes
    enable = 1'b0; fifo_level = 15'd2000;
    tick(30);
    check("disabled busy", 64'(busy), 64'd0);
    enable = 1'b1;
    wait_start(5, w);
    check("re-enable latency", 64'(w), 64'd1);
    check("re-enable payload_len", 64'(payload_len), 64'd1024);
    p0 = int'(pkt_count);
    serve(PB, 0, 1);
    check("drop enable packet completes", 64'(pkt_count), 64'(p0 + 1));
    fifo_level = '0; enable = 1'b1;
    tick(GAP + 2);

    // short packet sets sticky err_len
    fifo_level = 15'(PB);
    wait_start(5, w);
    serve(PB - 1, 0, 0);
    fifo_level = '0;
    check("short packet err_len", 64'(err_len), 64'd1);
    tick(GAP + 2);
    fifo_level = 15'(PB);
    wait_start(5, w);
    serve(PB, 0, 0);
    fifo_level = '0;
    check("err_len sticky", 64'(err_len), 64'd1);

    // sequence number wrap
    while (n_done % 16 != 15) begin
      fifo_level = 15'd8; flush_pulse();
      wait_start(GAP + 20, w);
      serve(8, 0, 0);
    end
    fifo_level = 15'd8; flush_pulse();
    wait_start(GAP + 20, w);
    check("seq_no before wrap", 64'(seq_no), 64'hF);
    serve(8, 0, 0);
    check("seq_no after wrap", 64'(seq_no), 64'h0);
    tick(GAP + 2);

    // asynchronous reset mid-send
    fifo_level = 15'(PB);
    wait_start(5, w);
    for (int i = 0; i < 10; i++) begin take_one(); tick(); byte_taken = 1'b0; end
    #2 rst_n = 1'b0;
    #1 check("async reset outputs", 64'({start_send, payload_len, seq_no, busy, err_len, pkt_count}), 64'd0);
    byte_taken = 1'b0; fifo_level = '0; flush_req = 1'b0; tx_done = 1'b0;
    @(posedge eth_clk); #1 rst_n = 1'b1;
    n_done = 0;
    tick(2);
    fifo_level = 15'd64; flush_pulse();
    wait_start(5, w);
    check("post-reset seq_no", 64'(seq_no), 64'd0);
    check("post-reset payload_len", 64'(payload_len), 64'd64);
    serve(64, 0, 0);
    check("post-reset pkt_count", 64'(pkt_count), 64'd1);
    check("post-reset err_len", 64'(err_len), 64'd0);
    tick(GAP + 2);

    // randomized traffic, judged by the per-cycle model compare
    for (int it = 0; it < 12; it++) begin
      if (!busy && $urandom_range(5) == 0) begin
        if ($urandom_range(1)) tx_done = 1'b1; else byte_taken = 1'b1;
        tick(); tx_done = 1'b0; byte_taken = 1'b0;
      end
      fifo_level = 15'($urandom_range(1, 1500));
      if ($urandom_range(1)) flush_pulse();
      wait_start(TO + GAP + 50, w);
      nb = m_len;
      if ($urandom_range(4) == 0) nb = nb + ($urandom_range(1) ? 1 : -1);
      if (nb < 0) nb = 0;
      serve(nb, 1'($urandom_range(1)), 0);
      if ($urandom_range(1)) fifo_level = '0;
    end
    tick(GAP + 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/eth_send_scheduler.md
Name: eth_send_scheduler

Overview:
- Sits in the eth_clk domain between the read side of the encoder-to-Ethernet async FIFO and the UDP/MAC transmit engine.
- Decides when a packet is launched and how many JPEG payload bytes it carries.
- Stamps each packet with a sequence number and enforces an inter-packet gap.
- Flushes partial data on an explicit flush request or after an idle timeout, and checks that the bytes actually consumed match the announced length.

Parameters:
- LEVEL_W, 15, width of the FIFO occupancy input in bytes.
- PAYLOAD_BYTES, 1024, full-packet payload size in bytes.
- TIMEOUT_CYC, 125000, idle cycles with a non-empty FIFO before a forced partial send.
- GAP_CYC, 96, minimum eth_clk cycles from tx_done to the next start_send.
- SEQ_W, 16, sequence number width.

Ports:
- eth_clk  in  1  transmit clock; all logic rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  when low, no new launch; an in-flight packet completes.
- fifo_level  in  LEVEL_W  bytes currently readable in the FIFO.
- flush_req  in  1  single-cycle pulse: send whatever is buffered.
- byte_taken  in  1  pulse per payload byte dequeued by the TX datapath.
- tx_done  in  1  pulse when the MAC finishes the frame.
- start_send  out  1  single-cycle launch pulse.
- payload_len  out  16  byte count for the current packet; stable from start_send until tx_done.
- seq_no  out  SEQ_W  sequence number of the current packet.
- busy  out  1  high in LAUNCH, SEND and GAP.
- err_len  out  1  sticky: consumed byte count differed from payload_len.
- pkt_count  out  32  packets completed since reset, wraps.

Behaviour:
Reset:
- All outputs are 0.
- State is IDLE, timers are 0, flush_pending is 0.
- seq_no=0 and is used by the first packet.
- Reset mid-packet aborts immediately; err_len is not set.

State machine (IDLE, LAUNCH, SEND, GAP):
- IDLE:
  - idle_timer increments when fifo_level!=0, saturates at TIMEOUT_CYC, and clears when fifo_level==0 or on a launch.
  - Launch condition: enable && (fifo_level>=PAYLOAD_BYTES || (fifo_level!=0 && (flush_pending || idle_timer==TIMEOUT_CYC))).
  - When the condition is true: latch payload_len = min(fifo_level, PAYLOAD_BYTES), zero-extended to 16 bits. Go to LAUNCH.
  - A full-size launch takes priority; the flush request stays pending if data remains afterwards.
- LAUNCH (exactly 1 cycle):
  - start_send=1; go to SEND.
  - start_send is registered, so it is high the cycle after the launch decision. Decision-to-pulse latency is 1 cycle.
- SEND:
  - take_cnt (16 bit) counts byte_taken pulses.
  - On tx_done: if take_cnt!=payload_len, set err_len.
  - Also on tx_done: seq_no+=1 (wraps at 2^SEQ_W), pkt_count+=1, take_cnt=0. Go to GAP.
  - byte_taken in the same cycle as tx_done is counted before the compare.
- GAP:
  - Counts GAP_CYC cycles, then goes to IDLE.
  - tx_done or byte_taken during GAP or IDLE sets err_len; counters are unaffected.
- flush_pending:
  - Set by flush_req in any state.
  - Cleared on a launch for which fifo_level<=PAYLOAD_BYTES, i.e. the launch drained everything visible.
  - flush_req while the FIFO is empty remains pending until data arrives.
- enable:
  - enable low in IDLE holds the state; idle_timer keeps counting.
  - Dropping enable during SEND/GAP does not abort.
- fifo_level is treated as a possibly stale lower bound, so no underflow check beyond the err_len compare.

Test Plan:
1. fifo_level steps 0→1024 with enable=1 → start_send one cycle after, payload_len=1024, seq_no=0; feed 1024 byte_taken then tx_done → err_len=0, seq_no=1, pkt_count=1.
2. fifo_level=300 held, no flush → no start_send for 125000 cycles; pulse on cycle 125001 with payload_len=300.
3. fifo_level=2500, flush_req pulsed → packets of 1024, 1024, 452 (level updated per consumption); flush_pending clears at the 452 launch; GAP of 96 cycles measured between each tx_done and the next start_send.
4. payload_len=1024 but only 1023 byte_taken before tx_done → err_len=1 and stays 1 through later good packets.
5. enable=0 with fifo_level=2000 → no start_send; enable=1 → start_send next decision cycle with payload_len=1024. Also drop enable mid-SEND → the packet completes.
6. seq_no preset to 0xFFFF via 65535 packets (or forced) → next packet uses 0x0000. Assert rst_n low mid-SEND → all outputs 0 asynchronously; after release, a packet launches normally with seq_no=0.
